// File: rtl/store_pkg.sv
// Shared types and default constants for the store checkout controller.
package store_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ALARM = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEFAULT_MAX_ITEMS = 15;
    localparam int DEFAULT_ALARM_MIN = 8;
    localparam int CNT_W             = 4;

endpackage

// File: rtl/store_alarm_timer.sv
// Saturating hold counter: enforces a minimum time in ALARM before the
// attendant acknowledge is allowed to release it.
module store_alarm_timer
    import store_pkg::*;
#(
    parameter int ALARM_MIN = DEFAULT_ALARM_MIN
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(ALARM_MIN);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments and a synchronous
    // reset so every flop updates together on the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/store_checkout.sv
// Checkout transaction controller: counts scanned items, raises an alarm on
// stolen items and pulses total_valid when the transaction closes.
module store_checkout
    import store_pkg::*;
#(
    parameter int MAX_ITEMS = DEFAULT_MAX_ITEMS,
    parameter int ALARM_MIN = DEFAULT_ALARM_MIN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             item_valid,
    input  logic             item_stolen,
    input  logic             item_discounted,
    output logic             item_ready,
    input  logic             checkout,
    input  logic             clear_alarm,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] discount_count,
    output logic             alarm,
    output logic             total_valid
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITEMS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] item_cnt_q, item_cnt_d;
    logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
    logic             hold_expired;
    logic             good_xfer;
    logic             stolen_xfer;

    store_alarm_timer #(
        .ALARM_MIN (ALARM_MIN)
    ) u_alarm_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != ALARM),
        .en      (state_q == ALARM),
        .expired (hold_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            item_cnt_q <= '0;
            disc_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            item_cnt_q <= item_cnt_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

    assign good_xfer   = item_valid && item_ready && !item_stolen;
    assign stolen_xfer = item_valid && item_ready && item_stolen;

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        item_cnt_d = item_cnt_q;
        disc_cnt_d = disc_cnt_q;
        unique case (state_q)
            IDLE, SCAN: begin
                if (stolen_xfer) begin
                    state_d = ALARM;
                end else begin
                    if (good_xfer) begin
                        item_cnt_d = item_cnt_q + 4'd1;
                        if (item_discounted) begin
                            disc_cnt_d = disc_cnt_q + 4'd1;
                        end
                    end
                    if (state_q == IDLE) begin
                        if (good_xfer) begin
                            state_d = SCAN;
                        end
                    end else if (checkout) begin
                        state_d = DONE;
                    end
                end
            end
            ALARM: begin
                if (clear_alarm && hold_expired) begin
                    state_d = (item_cnt_q != '0) ? SCAN : IDLE;
                end
            end
            DONE: begin
                state_d    = IDLE;
                item_cnt_d = '0;
                disc_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status depend on registered state only.
    always_comb begin
        item_ready  = (state_q == IDLE) || ((state_q == SCAN) && (item_cnt_q < MAX_CNT));
        alarm       = (state_q == ALARM);
        total_valid = (state_q == DONE);
    end

    assign item_count     = item_cnt_q;
    assign discount_count = disc_cnt_q;

endmodule

// File: tb/tb_store_checkout.sv
// Directed testbench for store_checkout: one task per scenario, each
// comparing the full status word against hand-computed values.
module tb_store_checkout;
    import store_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       item_valid = 1'b0;
    logic       item_stolen = 1'b0;
    logic       item_discounted = 1'b0;
    logic       checkout = 1'b0;
    logic       clear_alarm = 1'b0;
    logic       item_ready;
    logic       alarm;
    logic       total_valid;
    logic [3:0] item_count;
    logic [3:0] discount_count;
    logic [10:0] obs;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    store_checkout dut (
        .clk             (clk),
        .reset           (reset),
        .item_valid      (item_valid),
        .item_stolen     (item_stolen),
        .item_discounted (item_discounted),
        .item_ready      (item_ready),
        .checkout        (checkout),
        .clear_alarm     (clear_alarm),
        .item_count      (item_count),
        .discount_count  (discount_count),
        .alarm           (alarm),
        .total_valid     (total_valid)
    );

    // Status word: {alarm, item_ready, total_valid, item_count, discount_count}
    assign obs = {alarm, item_ready, total_valid, item_count, discount_count};

    function automatic logic [10:0] st(input logic a, input logic r, input logic t,
                                       input logic [3:0] ic, input logic [3:0] dc);
        return {a, r, t, ic, dc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic item(input logic s, input logic d);
        item_valid      = 1'b1;
        item_stolen     = s;
        item_discounted = d;
    endtask

    task automatic idle_in();
        item_valid      = 1'b0;
        item_stolen     = 1'b0;
        item_discounted = 1'b0;
        checkout        = 1'b0;
        clear_alarm     = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        exp = st(0, 1, 0, 4'd0, 4'd0);
        reset = 1'b1; item(1, 1); checkout = 1'b1; clear_alarm = 1'b1;
        step();
        n_total++;
        if (obs !== exp) $display("FAIL reset_priority: status=%h expected %h", obs, exp); else n_pass++;
        reset = 1'b0; idle_in();
        step();
        n_total++;
        if (obs !== exp) $display("FAIL reset_release: status=%h expected %h", obs, exp); else n_pass++;
    endtask

    task automatic test_basic();
        logic [10:0] exp;
        checkout = 1'b1;
        step();
        exp = st(0, 1, 0, 4'd0, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL idle_checkout_ignored: status=%h expected %h", obs, exp); else n_pass++;
        checkout = 1'b0;
        item(0, 1); step();
        exp = st(0, 1, 0, 4'd1, 4'd1);
        n_total++;
        if (obs !== exp) $display("FAIL basic_item1: status=%h expected %h", obs, exp); else n_pass++;
        item(0, 1); step();
        exp = st(0, 1, 0, 4'd2, 4'd2);
        n_total++;
        if (obs !== exp) $display("FAIL basic_item2: status=%h expected %h", obs, exp); else n_pass++;
        item(0, 0); step();
        exp = st(0, 1, 0, 4'd3, 4'd2);
        n_total++;
        if (obs !== exp) $display("FAIL basic_item3: status=%h expected %h", obs, exp); else n_pass++;
        idle_in(); checkout = 1'b1; step();
        exp = st(0, 0, 1, 4'd3, 4'd2);
        n_total++;
        if (obs !== exp) $display("FAIL basic_total: status=%h expected %h", obs, exp); else n_pass++;
        checkout = 1'b0; step();
        exp = st(0, 1, 0, 4'd0, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL basic_cleared: status=%h expected %h", obs, exp); else n_pass++;
        step();
        n_total++;
        if (obs !== exp) $display("FAIL basic_single_pulse: status=%h expected %h", obs, exp); else n_pass++;
    endtask

    task automatic test_alarm_idle();
        logic [10:0] exp;
        item(1, 0); step();
        exp = st(1, 0, 0, 4'd0, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL alarm_entry: status=%h expected %h", obs, exp); else n_pass++;
        idle_in();
        repeat (3) step();
        clear_alarm = 1'b1; step();
        n_total++;
        if (obs !== exp) $display("FAIL alarm_early_clear: status=%h expected %h", obs, exp); else n_pass++;
        clear_alarm = 1'b0;
        repeat (3) step();
        clear_alarm = 1'b1; step();
        n_total++;
        if (obs !== exp) $display("FAIL alarm_clear_cycle7: status=%h expected %h", obs, exp); else n_pass++;
        step();
        exp = st(0, 1, 0, 4'd0, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL alarm_clear_cycle8: status=%h expected %h", obs, exp); else n_pass++;
        idle_in();
    endtask

    task automatic test_stolen_in_scan();
        logic [10:0] exp;
        item(0, 0); step();
        item(0, 0); step();
        exp = st(0, 1, 0, 4'd2, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL scan_two_items: status=%h expected %h", obs, exp); else n_pass++;
        item(1, 1); checkout = 1'b1; step();
        exp = st(1, 0, 0, 4'd2, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL stolen_with_checkout: status=%h expected %h", obs, exp); else n_pass++;
        checkout = 1'b0; item(0, 1); clear_alarm = 1'b1;
        repeat (8) step();
        n_total++;
        if (obs !== exp) $display("FAIL alarm_ignores_items: status=%h expected %h", obs, exp); else n_pass++;
        item_valid = 1'b0; step();
        exp = st(0, 1, 0, 4'd2, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL alarm_exit_scan: status=%h expected %h", obs, exp); else n_pass++;
        idle_in(); checkout = 1'b1; step();
        exp = st(0, 0, 1, 4'd2, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL scan_resume_total: status=%h expected %h", obs, exp); else n_pass++;
        checkout = 1'b0; step();
    endtask

    task automatic test_full();
        logic [10:0] exp;
        for (int i = 0; i < 15; i++) begin
            item(0, (i % 3) == 0); step();
            exp = st(0, (i + 1) < 15, 0, 4'(i + 1), 4'(i / 3 + 1));
            n_total++;
            if (obs !== exp) $display("FAIL full_fill_%0d: status=%h expected %h", i + 1, obs, exp); else n_pass++;
        end
        item(0, 1); repeat (2) step();
        exp = st(0, 0, 0, 4'd15, 4'd5);
        n_total++;
        if (obs !== exp) $display("FAIL full_ignores_item: status=%h expected %h", obs, exp); else n_pass++;
        item(1, 0); step();
        n_total++;
        if (obs !== exp) $display("FAIL full_ignores_stolen: status=%h expected %h", obs, exp); else n_pass++;
        idle_in(); checkout = 1'b1; step();
        exp = st(0, 0, 1, 4'd15, 4'd5);
        n_total++;
        if (obs !== exp) $display("FAIL full_total: status=%h expected %h", obs, exp); else n_pass++;
        checkout = 1'b0; step();
        exp = st(0, 1, 0, 4'd0, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL full_cleared: status=%h expected %h", obs, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        item(0, 1); step();
        item(0, 0); checkout = 1'b1; step();
        exp = st(0, 0, 1, 4'd2, 4'd1);
        n_total++;
        if (obs !== exp) $display("FAIL item_with_checkout: status=%h expected %h", obs, exp); else n_pass++;
        checkout = 1'b0; item(0, 1); step();
        exp = st(0, 1, 0, 4'd0, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL done_not_ready: status=%h expected %h", obs, exp); else n_pass++;
        idle_in();
    endtask

    task automatic test_reset_abort();
        logic [10:0] exp;
        item(0, 1); step();
        item(1, 0); step();
        exp = st(1, 0, 0, 4'd1, 4'd1);
        n_total++;
        if (obs !== exp) $display("FAIL abort_alarm_entry: status=%h expected %h", obs, exp); else n_pass++;
        idle_in(); reset = 1'b1; step();
        reset = 1'b0;
        exp = st(0, 1, 0, 4'd0, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL reset_in_alarm: status=%h expected %h", obs, exp); else n_pass++;
        repeat (2) step();
        n_total++;
        if (obs !== exp) $display("FAIL no_pulse_after_alarm_reset: status=%h expected %h", obs, exp); else n_pass++;
        item(0, 0); step();
        idle_in(); checkout = 1'b1; step();
        exp = st(0, 0, 1, 4'd1, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL abort_done_entry: status=%h expected %h", obs, exp); else n_pass++;
        checkout = 1'b0; reset = 1'b1; step();
        reset = 1'b0;
        exp = st(0, 1, 0, 4'd0, 4'd0);
        n_total++;
        if (obs !== exp) $display("FAIL reset_in_done: status=%h expected %h", obs, exp); else n_pass++;
        step();
        n_total++;
        if (obs !== exp) $display("FAIL no_pulse_after_done_reset: status=%h expected %h", obs, exp); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alarm_idle();
        test_stolen_in_scan();
        test_full();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
